ssm_demux: RTL and testbench



---
 rtl/ssm_demux.sv | 147 ++++++++++++++
 tb/tb_ssm_demux.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/ssm_demux.sv
// Distributes the multiplexed muxWord stream into four show-ahead balance FIFOs:
// round-robin prefill first, then refills in the order the parsers consumed words.
module ssm_demux #(
    parameter int WORD_W     = 128,
    parameter int FIFO_DEPTH = 4,
    parameter int INIT_WORDS = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_dec,
    input  logic [WORD_W-1:0] in_data,
    input  logic              in_vld,
    output logic              in_rdy,
    input  logic [3:0]        codec_data_rd_en,
    output logic [WORD_W-1:0] codec_data_ssm0,
    output logic [WORD_W-1:0] codec_data_ssm1,
    output logic [WORD_W-1:0] codec_data_ssm2,
    output logic [WORD_W-1:0] codec_data_ssm3,
    output logic              init_done,
    output logic              underflow,
    output logic [11:0]       fill_ssm
);
    localparam int QD  = 4 * INIT_WORDS;
    localparam int QIW = $clog2(QD);
    localparam int QCW = $clog2(QD + 1);
    localparam int PW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW  = $clog2(FIFO_DEPTH + 1);
    localparam logic [QCW-1:0] QD_C = QCW'(QD);

    typedef enum logic [1:0] {IDLE, PREFILL, RUN} state_t;

    state_t            state_reg, state_next;
    logic [QCW-1:0]    pf_cnt_reg;
    logic [1:0]        q_reg [QD];
    logic [1:0]        q_next [QD];
    logic [QCW-1:0]    q_cnt_reg, q_cnt_next;
    logic              underflow_reg;
    logic              handshake, q_pop;
    logic [1:0]        wr_sel;
    logic [3:0]        wr_en, pop, nonempty;
    logic [WORD_W-1:0] head [4];

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            IDLE:    if (start_dec) state_next = PREFILL;
            PREFILL: if (handshake && pf_cnt_reg == QD_C - 1'b1) state_next = RUN;
            RUN:     state_next = RUN;
            default: state_next = IDLE;
        endcase
    end

    // Readiness comes from registered state only, never from in_vld.
    assign in_rdy    = (state_reg == PREFILL) || (state_reg == RUN && q_cnt_reg != '0);
    assign handshake = in_vld && in_rdy;
    assign q_pop     = handshake && (state_reg == RUN);
    assign wr_sel    = (state_reg == PREFILL) ? pf_cnt_reg[1:0] : q_reg[0];
    assign init_done = (state_reg == RUN);
    assign underflow = underflow_reg;

    // Request queue: drop the head on a refill, then append this cycle's pops in bit order.
    always_comb begin
        q_next     = q_reg;
        q_cnt_next = q_cnt_reg;
        if (q_pop) begin
            for (int i = 0; i < QD - 1; i++) begin
                q_next[i] = q_reg[i + 1];
            end
            q_cnt_next = q_cnt_reg - 1'b1;
        end
        for (int n = 0; n < 4; n++) begin
            if (pop[n] && q_cnt_next < QD_C) begin
                q_next[q_cnt_next[QIW-1:0]] = 2'(n);
                q_cnt_next = q_cnt_next + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            pf_cnt_reg    <= '0;
            q_cnt_reg     <= '0;
            underflow_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            q_cnt_reg <= q_cnt_next;
            if (state_reg == PREFILL && handshake) begin
                pf_cnt_reg <= pf_cnt_reg + 1'b1;
            end
            if (|(codec_data_rd_en & ~pop)) begin
                underflow_reg <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        q_reg <= q_next;
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_fifo
            logic [WORD_W-1:0] mem [FIFO_DEPTH];
            logic [PW-1:0]     wr_ptr_reg, rd_ptr_reg;
            logic [CW-1:0]     count_reg;

            assign wr_en[gi]    = handshake && (wr_sel == 2'(gi));
            assign nonempty[gi] = (count_reg != '0);
            assign pop[gi]      = (state_reg == RUN) && codec_data_rd_en[gi] && nonempty[gi];
            assign head[gi]     = nonempty[gi] ? mem[rd_ptr_reg] : '0;
            assign fill_ssm[3*gi +: 3] = (count_reg > CW'(FIFO_DEPTH)) ? 3'(FIFO_DEPTH)
                                                                      : 3'(count_reg);

            always_ff @(posedge clk) begin
                if (wr_en[gi]) begin
                    mem[wr_ptr_reg] <= in_data;
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    wr_ptr_reg <= '0;
                    rd_ptr_reg <= '0;
                    count_reg  <= '0;
                end else begin
                    if (wr_en[gi]) begin
                        wr_ptr_reg <= (wr_ptr_reg == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_reg + 1'b1;
                    end
                    if (pop[gi]) begin
                        rd_ptr_reg <= (rd_ptr_reg == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_reg + 1'b1;
                    end
                    case ({wr_en[gi], pop[gi]})
                        2'b10:   count_reg <= count_reg + 1'b1;
                        2'b01:   count_reg <= count_reg - 1'b1;
                        default: count_reg <= count_reg;
                    endcase
                end
            end
        end
    endgenerate

    assign codec_data_ssm0 = head[0];
    assign codec_data_ssm1 = head[1];
    assign codec_data_ssm2 = head[2];
    assign codec_data_ssm3 = head[3];
endmodule

// File: tb/tb_ssm_demux.sv
// Bench for ssm_demux: directed scenarios plus a random soak, all checked against
// a queue-based model of prefill order and consumption-ordered refill.
module tb_ssm_demux;
    localparam int INIT  = 2;
    localparam int DEPTH = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b0, start_dec = 1'b0, in_vld = 1'b0;
    logic [127:0] in_data = '0;
    logic [3:0]   rd_en = '0;
    logic         in_rdy, init_done, underflow;
    logic [127:0] ssm0, ssm1, ssm2, ssm3;
    logic [11:0]  fill_ssm;
    logic [127:0] h [4];

    // second instance with a single preloaded word per substream
    logic         start_b = 1'b0, vld_b = 1'b0;
    logic [127:0] data_b = '0;
    logic [3:0]   rd_b = '0;
    logic         rdy_b, init_b, uf_b;
    logic [127:0] b0, b1, b2, b3;
    logic [11:0]  fill_b;

    always #5 clk = ~clk;

    ssm_demux #(.WORD_W(128), .FIFO_DEPTH(DEPTH), .INIT_WORDS(INIT)) dut (
        .clk(clk), .rst(rst), .start_dec(start_dec), .in_data(in_data), .in_vld(in_vld),
        .in_rdy(in_rdy), .codec_data_rd_en(rd_en),
        .codec_data_ssm0(ssm0), .codec_data_ssm1(ssm1),
        .codec_data_ssm2(ssm2), .codec_data_ssm3(ssm3),
        .init_done(init_done), .underflow(underflow), .fill_ssm(fill_ssm));

    ssm_demux #(.WORD_W(128), .FIFO_DEPTH(DEPTH), .INIT_WORDS(1)) dut_b (
        .clk(clk), .rst(rst), .start_dec(start_b), .in_data(data_b), .in_vld(vld_b),
        .in_rdy(rdy_b), .codec_data_rd_en(rd_b),
        .codec_data_ssm0(b0), .codec_data_ssm1(b1),
        .codec_data_ssm2(b2), .codec_data_ssm3(b3),
        .init_done(init_b), .underflow(uf_b), .fill_ssm(fill_b));

    assign h[0] = ssm0;
    assign h[1] = ssm1;
    assign h[2] = ssm2;
    assign h[3] = ssm3;

    // reference model: mode 0 idle, 1 prefill, 2 run
    typedef logic [127:0] wq_t [$];
    wq_t m_fifo [4];
    int  m_req [$];
    int  m_mode = 0;
    int  m_pf = 0;
    bit  m_uf = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit model_rdy();
        return (m_mode == 1) || (m_mode == 2 && m_req.size() > 0);
    endfunction

    function automatic logic [127:0] model_head(input int n);
        return (m_fifo[n].size() > 0) ? m_fifo[n][0] : '0;
    endfunction

    task automatic compare_all();
        check_val("in_rdy", in_rdy, model_rdy());
        for (int n = 0; n < 4; n++) begin
            check_val($sformatf("head%0d", n), h[n], model_head(n));
            check_val($sformatf("fill%0d", n), fill_ssm[3*n +: 3], m_fifo[n].size());
        end
        check_val("init_done", init_done, m_mode == 2);
        check_val("underflow", underflow, m_uf);
    endtask

    task automatic step(input bit r, input bit sd, input bit v, input logic [127:0] d,
                        input logic [3:0] re);
        bit hs;
        int tgt;
        rst = r; start_dec = sd; in_vld = v; in_data = d; rd_en = re;
        hs = v && model_rdy();
        @(posedge clk);
        if (r) begin
            for (int n = 0; n < 4; n++) m_fifo[n].delete();
            m_req.delete();
            m_mode = 0; m_pf = 0; m_uf = 1'b0;
        end else begin
            tgt = 0;
            if (hs) begin
                tgt = (m_mode == 1) ? (m_pf % 4) : m_req.pop_front();
                $display("xfer word %h -> ssm%0d", d, tgt);
            end
            for (int n = 0; n < 4; n++) begin
                if (re[n]) begin
                    if (m_mode == 2 && m_fifo[n].size() > 0) begin
                        void'(m_fifo[n].pop_front());
                        m_req.push_back(n);
                    end else begin
                        m_uf = 1'b1;
                    end
                end
            end
            if (hs) m_fifo[tgt].push_back(d);
            if (m_mode == 0 && sd) m_mode = 1;
            else if (m_mode == 1 && hs) begin
                m_pf++;
                if (m_pf == 4 * INIT) m_mode = 2;
            end
        end
        @(negedge clk);
        compare_all();
    endtask

    initial begin
        logic [3:0] mask;
        int pend;

        // reset
        step(1, 0, 0, '0, 4'b0000);
        step(1, 0, 0, '0, 4'b0000);
        check_val("rst_rdy", in_rdy, 1'b0);
        check_val("rst_fill", fill_ssm, 12'd0);

        // prefill: init_done rises exactly 8 cycles after start_dec
        step(0, 1, 0, '0, 4'b0000);
        for (int i = 0; i < 8; i++) begin
            step(0, 0, 1, 128'(i), 4'b0000);
            check_val("init_done_rise", init_done, i == 7);
        end
        for (int n = 0; n < 4; n++) begin
            check_val("prefill_head", h[n], 128'(n));
            check_val("prefill_fill", fill_ssm[3*n +: 3], 3'd2);
        end

        // concurrent pops, then refill order ssm0..ssm3
        step(0, 0, 0, '0, 4'b1111);
        check_val("pop4_rdy", in_rdy, 1'b1);
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 1, 128'(8 + i), 4'b0000);
            check_val("refill_fill", fill_ssm[3*i +: 3], 3'd2);
            check_val("refill_rdy", in_rdy, i < 3);
        end
        step(0, 0, 1, 128'hEE, 4'b0000);
        check_val("refill_extra", fill_ssm, {4{3'd2}});

        // ordering with backpressure: queue [2,0]
        step(0, 0, 0, '0, 4'b0100);
        step(0, 0, 0, '0, 4'b0001);
        check_val("bp_fill2", fill_ssm[8:6], 3'd1);
        check_val("bp_fill0", fill_ssm[2:0], 3'd1);
        step(0, 0, 1, 128'hA0, 4'b0000);
        check_val("bp_first_ssm2", fill_ssm[8:6], 3'd2);
        check_val("bp_first_ssm0", fill_ssm[2:0], 3'd1);
        step(0, 0, 1, 128'hA1, 4'b0000);
        check_val("bp_second_ssm0", fill_ssm[2:0], 3'd2);
        check_val("bp_done_rdy", in_rdy, 1'b0);

        // underflow on the single-word instance
        start_b = 1'b1;
        step(0, 0, 0, '0, 4'b0000);
        start_b = 1'b0;
        for (int i = 0; i < 4; i++) begin
            vld_b = 1'b1; data_b = 128'(16 + i);
            step(0, 0, 0, '0, 4'b0000);
        end
        vld_b = 1'b0;
        check_val("b_init", init_b, 1'b1);
        check_val("b_head3", b3, 128'h13);
        check_val("b_rdy_idle", rdy_b, 1'b0);
        rd_b = 4'b1000;
        step(0, 0, 0, '0, 4'b0000);
        check_val("b_pop1_uf", uf_b, 1'b0);
        check_val("b_pop1_head", b3, 128'h0);
        check_val("b_pop1_rdy", rdy_b, 1'b1);
        step(0, 0, 0, '0, 4'b0000);
        rd_b = 4'b0000;
        check_val("b_pop2_uf", uf_b, 1'b1);
        check_val("b_pop2_head", b3, 128'h0);
        vld_b = 1'b1; data_b = 128'h55;
        step(0, 0, 0, '0, 4'b0000);
        vld_b = 1'b0;
        check_val("b_noextra_rdy", rdy_b, 1'b0);
        check_val("b_refill_fill", fill_b[11:9], 3'd1);
        check_val("b_refill_head", b3, 128'h55);
        step(0, 0, 0, '0, 4'b0000);
        check_val("b_uf_sticky", uf_b, 1'b1);

        // reset mid-prefill, then prefill again from ssm0
        step(1, 0, 0, '0, 4'b0000);
        step(0, 1, 0, '0, 4'b0000);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 128'(48 + i), 4'b0000);
        step(1, 0, 1, 128'h33, 4'b0000);
        check_val("mid_rst_rdy", in_rdy, 1'b0);
        check_val("mid_rst_fill", fill_ssm, 12'd0);
        check_val("mid_rst_head0", ssm0, 128'h0);
        check_val("mid_rst_uf_b", uf_b, 1'b0);
        step(0, 1, 0, '0, 4'b0000);
        for (int i = 0; i < 8; i++) step(0, 0, 1, 128'(64 + i), 4'b0000);
        check_val("reprefill_head0", ssm0, 128'h40);
        check_val("reprefill_head1", ssm1, 128'h41);

        // random soak: pops only on non-empty FIFOs, so no underflow expected
        for (int c = 0; c < 10000; c++) begin
            for (int n = 0; n < 4; n++) mask[n] = (m_fifo[n].size() > 0);
            step(0, 0, 1'($urandom_range(0, 1)),
                 {$urandom, $urandom, $urandom, $urandom},
                 4'($urandom_range(0, 15)) & mask);
            for (int n = 0; n < 4; n++) begin
                pend = 0;
                foreach (m_req[k]) if (m_req[k] == n) pend++;
                check_val($sformatf("invariant%0d", n), 128'(int'(fill_ssm[3*n +: 3]) + pend), 128'(INIT));
            end
        end
        check_val("soak_underflow", underflow, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
